// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shifts, rotates, asr, clear, plus a multi-step engine.
// Optional macro SHIFT_ZERO_FLAG_EN adds zero_o = (Y_o == 0).
module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_L,
    input  logic             data_R,
    output logic [WIDTH-1:0] Y_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic             zero_o
`endif
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHL   = 3'b010,
        M_SHR   = 3'b011,
        M_ROTL  = 3'b100,
        M_ROTR  = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    mode_t            run_mode_q, run_mode_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             sout_q, sout_d;
    logic             busy_q;
    logic             done_q, done_d;

    mode_t            step_mode;
    logic [WIDTH-1:0] step_y;
    logic             step_sout;
    logic             single_step_mode;
    logic [AMT_W-1:0] start_count;

    // One step of whichever mode is active: the latched mode in RUN, mode_i otherwise.
    always_comb begin
        step_mode = (state_q == RUN) ? run_mode_q : mode_t'(mode_i);
        step_y    = y_q;
        step_sout = sout_q;
        case (step_mode)
            M_HOLD:  ;
            M_LOAD:  step_y = data_i;
            M_SHL: begin
                step_y    = {y_q[WIDTH-2:0], data_R};
                step_sout = y_q[WIDTH-1];
            end
            M_SHR: begin
                step_y    = {data_L, y_q[WIDTH-1:1]};
                step_sout = y_q[0];
            end
            M_ROTL: begin
                step_y    = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
                step_sout = y_q[WIDTH-1];
            end
            M_ROTR: begin
                step_y    = {y_q[0], y_q[WIDTH-1:1]};
                step_sout = y_q[0];
            end
            M_ASR: begin
                step_y    = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                step_sout = y_q[0];
            end
            M_CLEAR: begin
                step_y    = '0;
                step_sout = 1'b0;
            end
        endcase
    end

    // Hold, load and clear are idempotent, so a multi-step request runs them exactly once.
    always_comb begin
        single_step_mode = (mode_i == M_HOLD) || (mode_i == M_LOAD) || (mode_i == M_CLEAR);
        start_count      = single_step_mode ? CNT_ONE : amt_i;
    end

    always_comb begin
        state_d    = state_q;
        run_mode_d = run_mode_q;
        count_d    = count_q;
        y_d        = y_q;
        sout_d     = sout_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    run_mode_d = mode_t'(mode_i);
                    count_d    = start_count;
                    if (start_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (en_i) begin
                    y_d    = step_y;
                    sout_d = step_sout;
                end
            end
            RUN: begin
                y_d     = step_y;
                sout_d  = step_sout;
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_mode_q <= M_HOLD;
            count_q    <= '0;
            y_q        <= '0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_mode_q <= run_mode_d;
            count_q    <= count_d;
            y_q        <= y_d;
            sout_q     <= sout_d;
            busy_q     <= (state_d == RUN);
            done_q     <= done_d;
        end
    end

    assign Y_o    = y_q;
    assign sout_o = sout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

`ifdef SHIFT_ZERO_FLAG_EN
    assign zero_o = (y_q == '0);
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8 and WIDTH=16; expectations flow through a scoreboard queue.
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        en, start, dl, dr;
    logic [2:0]  mode;
    logic [3:0]  amt;
    logic [7:0]  data;
    logic [7:0]  y;
    logic        sout, busy, done;

    logic        en16, start16, dl16, dr16;
    logic [2:0]  mode16;
    logic [4:0]  amt16;
    logic [15:0] data16;
    logic [15:0] y16;
    logic        sout16, busy16, done16;

`ifdef SHIFT_ZERO_FLAG_EN
    logic        zero, zero16;
`endif

    typedef struct {
        logic [15:0] y;
        logic        sout;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .start_i(start), .mode_i(mode),
        .amt_i(amt), .data_i(data), .data_L(dl), .data_R(dr),
        .Y_o(y), .sout_o(sout), .busy_o(busy), .done_o(done)
`ifdef SHIFT_ZERO_FLAG_EN
        , .zero_o(zero)
`endif
    );

    univ_shift_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en_i(en16), .start_i(start16), .mode_i(mode16),
        .amt_i(amt16), .data_i(data16), .data_L(dl16), .data_R(dr16),
        .Y_o(y16), .sout_o(sout16), .busy_o(busy16), .done_o(done16)
`ifdef SHIFT_ZERO_FLAG_EN
        , .zero_o(zero16)
`endif
    );

    task automatic applyStimulus(input logic e, input logic s, input logic [2:0] m,
                                 input logic [3:0] a, input logic [7:0] d,
                                 input logic l, input logic r);
        en = e; start = s; mode = m; amt = a; data = d; dl = l; dr = r;
    endtask

    task automatic applyStimulus16(input logic e, input logic s, input logic [2:0] m,
                                   input logic [4:0] a, input logic [15:0] d,
                                   input logic l, input logic r);
        en16 = e; start16 = s; mode16 = m; amt16 = a; data16 = d; dl16 = l; dr16 = r;
    endtask

    task automatic pushExpect(input logic [15:0] y_e, input logic s_e, input logic b_e, input logic d_e);
        exp_t e;
        e.y = y_e; e.sout = s_e; e.busy = b_e; e.done = d_e;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] y_obs, input logic s_obs,
                               input logic b_obs, input logic d_obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            fails++;
            $error("[TB] FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        tests++;
        assert (y_obs === e.y) else begin
            fails++;
            $error("[TB] FAIL %s Y_o: got %h expected %h", tag, y_obs, e.y);
        end
        tests++;
        assert (s_obs === e.sout) else begin
            fails++;
            $error("[TB] FAIL %s sout_o: got %b expected %b", tag, s_obs, e.sout);
        end
        tests++;
        assert (b_obs === e.busy) else begin
            fails++;
            $error("[TB] FAIL %s busy_o: got %b expected %b", tag, b_obs, e.busy);
        end
        tests++;
        assert (d_obs === e.done) else begin
            fails++;
            $error("[TB] FAIL %s done_o: got %b expected %b", tag, d_obs, e.done);
        end
    endtask

    task automatic chk8(input string tag);
        checkOutput(tag, {8'h00, y}, sout, busy, done);
    endtask

    task automatic chk16(input string tag);
        checkOutput(tag, y16, sout16, busy16, done16);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] val, input logic sout_e, input string tag);
        applyStimulus(1'b1, 1'b0, 3'b001, 4'd0, val, 1'b0, 1'b0);
        pushExpect({8'h00, val}, sout_e, 1'b0, 1'b0);
        step();
        chk8(tag);
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] pat;
        pat   = 16'hB38D;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        applyStimulus16(1'b0, 1'b0, 3'b000, 5'd0, 16'h0000, 1'b0, 1'b0);
        #2;
        pushExpect(16'h0000, 1'b0, 1'b0, 1'b0); chk8("reset");
        pushExpect(16'h0000, 1'b0, 1'b0, 1'b0); chk16("reset16");
`ifdef SHIFT_ZERO_FLAG_EN
        tests++;
        assert (zero === 1'b1) else begin
            fails++;
            $error("[TB] FAIL zero_reset: got %b expected 1", zero);
        end
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        // Asynchronous reset in the middle of a rotate run
        loadByte(8'hA5, 1'b0, "load_a5");
        applyStimulus(1'b0, 1'b1, 3'b100, 4'd5, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h00A5, 1'b0, 1'b1, 1'b0); step(); chk8("rotl_start");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h004B, 1'b1, 1'b1, 1'b0); step(); chk8("rotl_step1");
        pushExpect(16'h0096, 1'b0, 1'b1, 1'b0); step(); chk8("rotl_step2");
        #2 rst_n = 1'b0;
        #1;
        pushExpect(16'h0000, 1'b0, 1'b0, 1'b0); chk8("reset_midrun");
        @(posedge clk); #1 rst_n = 1'b1;

        // Single-step operations
        loadByte(8'h81, 1'b0, "load_81");
        applyStimulus(1'b1, 1'b0, 3'b011, 4'd0, 8'h00, 1'b1, 1'b0);
        pushExpect(16'h00C0, 1'b1, 1'b0, 1'b0); step(); chk8("shr_dl1");
        applyStimulus(1'b1, 1'b0, 3'b110, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h00E0, 1'b0, 1'b0, 1'b0); step(); chk8("asr");
        applyStimulus(1'b1, 1'b0, 3'b010, 4'd0, 8'h00, 1'b0, 1'b1);
        pushExpect(16'h00C1, 1'b1, 1'b0, 1'b0); step(); chk8("shl_dr1");
        applyStimulus(1'b1, 1'b0, 3'b111, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h0000, 1'b0, 1'b0, 1'b0); step(); chk8("clear");

        // Multi-step rotate right by 3
        loadByte(8'h96, 1'b0, "load_96");
        applyStimulus(1'b0, 1'b1, 3'b101, 4'd3, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h0096, 1'b0, 1'b1, 1'b0); step(); chk8("rotr_start");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h004B, 1'b0, 1'b1, 1'b0); step(); chk8("rotr_1");
        pushExpect(16'h00A5, 1'b1, 1'b1, 1'b0); step(); chk8("rotr_2");
        pushExpect(16'h00D2, 1'b1, 1'b0, 1'b1); step(); chk8("rotr_done");
        pushExpect(16'h00D2, 1'b1, 1'b0, 1'b0); step(); chk8("rotr_after");

        // amt=0 completes immediately without entering RUN
        applyStimulus(1'b0, 1'b1, 3'b010, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h00D2, 1'b1, 1'b0, 1'b1); step(); chk8("shl_amt0");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h00D2, 1'b1, 1'b0, 1'b0); step(); chk8("shl_amt0_after");

        // Full-width shift fills with serial input
        applyStimulus(1'b1, 1'b0, 3'b111, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h0000, 1'b0, 1'b0, 1'b0); step(); chk8("clear2");
        applyStimulus(1'b0, 1'b1, 3'b010, 4'd8, 8'h00, 1'b0, 1'b1);
        pushExpect(16'h0000, 1'b0, 1'b1, 1'b0); step(); chk8("shl8_start");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b1);
        repeat (7) step();
        pushExpect(16'h007F, 1'b0, 1'b1, 1'b0); chk8("shl8_step7");
        pushExpect(16'h00FF, 1'b0, 1'b0, 1'b1); step(); chk8("shl8_done");

        // Rotate count beyond WIDTH wraps
        loadByte(8'h01, 1'b0, "load_01");
        applyStimulus(1'b0, 1'b1, 3'b100, 4'd9, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h0001, 1'b0, 1'b1, 1'b0); step(); chk8("rotl9_start");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        repeat (8) step();
        pushExpect(16'h0001, 1'b1, 1'b1, 1'b0); chk8("rotl9_step8");
        pushExpect(16'h0002, 1'b0, 1'b0, 1'b1); step(); chk8("rotl9_done");

        // Control inputs are ignored while running
        loadByte(8'hF0, 1'b0, "load_f0");
        applyStimulus(1'b0, 1'b1, 3'b011, 4'd4, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h00F0, 1'b0, 1'b1, 1'b0); step(); chk8("shr4_start");
        applyStimulus(1'b1, 1'b1, 3'b001, 4'd7, 8'h55, 1'b0, 1'b0);
        pushExpect(16'h0078, 1'b0, 1'b1, 1'b0); step(); chk8("shr4_1");
        applyStimulus(1'b0, 1'b0, 3'b001, 4'd2, 8'hAA, 1'b0, 1'b0);
        pushExpect(16'h003C, 1'b0, 1'b1, 1'b0); step(); chk8("shr4_2");
        applyStimulus(1'b1, 1'b1, 3'b111, 4'd0, 8'hFF, 1'b0, 1'b0);
        pushExpect(16'h001E, 1'b0, 1'b1, 1'b0); step(); chk8("shr4_3");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h000F, 1'b0, 1'b0, 1'b1); step(); chk8("shr4_done");
        pushExpect(16'h000F, 1'b0, 1'b0, 1'b0); step(); chk8("shr4_one_pulse");

        // Multi-step load, then a new start in the done cycle
        applyStimulus(1'b0, 1'b1, 3'b001, 4'd0, 8'h80, 1'b0, 1'b0);
        pushExpect(16'h000F, 1'b0, 1'b1, 1'b0); step(); chk8("mload_start");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h80, 1'b0, 1'b0);
        pushExpect(16'h0080, 1'b0, 1'b0, 1'b1); step(); chk8("mload_done");
        applyStimulus(1'b0, 1'b1, 3'b110, 4'd2, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h0080, 1'b0, 1'b1, 1'b0); step(); chk8("b2b_start");
        applyStimulus(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        pushExpect(16'h00C0, 1'b0, 1'b1, 1'b0); step(); chk8("b2b_1");
        pushExpect(16'h00E0, 1'b0, 1'b0, 1'b1); step(); chk8("b2b_done");

        // WIDTH=16: serial stream fed MSB first through a 16-step shift
        applyStimulus16(1'b0, 1'b1, 3'b010, 5'd16, 16'h0000, 1'b0, 1'b0);
        pushExpect(16'h0000, 1'b0, 1'b1, 1'b0); step(); chk16("w16_start");
        for (int i = 15; i >= 1; i--) begin
            applyStimulus16(1'b0, 1'b0, 3'b000, 5'd0, 16'h0000, 1'b0, pat[i]);
            step();
        end
        applyStimulus16(1'b0, 1'b0, 3'b000, 5'd0, 16'h0000, 1'b0, pat[0]);
        pushExpect(pat, 1'b0, 1'b0, 1'b1); step(); chk16("w16_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
